ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage soft-core pipeline. It consumes the ID/EX bundle, applies EX/MEM and MEM/WB forwarding, and runs the single-cycle ALU or a 32-cycle iterative multiplier. It resolves branches and registers results into the EX/MEM pipeline register. It raises `EX_Stall` while a multiply is in flight, and that signal is ORed into the upstream stage holds.

## Interface
Parameters:
- `MUL_CYCLES`, 32: multiplier iterations, one bit per cycle.

Ports:
- `clk` in 1: pipeline clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ID_EX_MemToReg`, `ID_EX_RegWrite`, `ID_EX_MemRead`, `ID_EX_MemWrite`, `ID_EX_Branch`, `ID_EX_ALUSrc` in 1 each: control bundle from ID/EX.
- `ID_EX_ALUOp` in 6: operation code.
- `ID_EX_BranchTarget`, `ID_EX_ReadData1`, `ID_EX_ReadData2`, `ID_EX_SignExtImm` in 32 each.
- `ID_EX_Rs`, `ID_EX_WriteReg` in 5 each: source register of A; destination register, also the source of ReadData2.
- `MEM_WB_RegWrite` in 1, `MEM_WB_WriteReg` in 5, `MEM_WB_WriteData` in 32: writeback forwarding path.
- `MemoryStall` in 1: downstream hold; freezes all EX state.
- `EX_Stall` out 1: holds IF/ID and ID/EX.
- `EX_MEM_MemToReg`, `EX_MEM_RegWrite`, `EX_MEM_MemRead`, `EX_MEM_MemWrite`, `EX_MEM_BranchTaken` out 1 each.
- `EX_MEM_ALUResult`, `EX_MEM_StoreData`, `EX_MEM_BranchTarget` out 32 each.
- `EX_MEM_WriteReg` out 5.

## Operation
- ALUOp encodings:
  - 000000 ADD
  - 000001 SUB
  - 000010 AND
  - 000011 OR
  - 000100 XOR
  - 000101 SLT: signed; result 1 or 0.
  - 000110 SLL: shift by B[4:0].
  - 000111 SRL: logical shift by B[4:0].
  - 001000 MUL: low 32 bits of A*B.
  - 010101 NOP: result 0.
  - Any other code behaves as NOP.
- Operand A is the forwarded ReadData1.
- Store data is the forwarded ReadData2.
- Operand B = ALUSrc ? SignExtImm : store data.
- Forwarding priority, applied separately to the Rs and WriteReg sources:
  - First, EX/MEM: when `EX_MEM_RegWrite`, `EX_MEM_MemToReg`=0, and `EX_MEM_WriteReg` equals the source, use `EX_MEM_ALUResult`.
  - Otherwise, MEM/WB: when `MEM_WB_RegWrite` and `MEM_WB_WriteReg` equals the source, use `MEM_WB_WriteData`.
  - Otherwise, use the ID/EX value.
  - Register 0 is never forwarded.
- Arithmetic wraps modulo 2^32; no overflow flag.
- Branch: `EX_MEM_BranchTaken` = `ID_EX_Branch` AND (A == store data). `EX_MEM_BranchTarget` passes through from `ID_EX_BranchTarget`.
- Multiplier FSM:
  - IDLE: if ALUOp is MUL and `MemoryStall`=0, latch A and B, clear the accumulator and counter, and go to BUSY.
  - BUSY: each cycle, add the multiplicand to the accumulator if multiplier[0] is 1, then shift the multiplicand left and the multiplier right, and increment the counter. After `MUL_CYCLES` iterations, go to DONE.
  - DONE: load EX/MEM with the product and the MUL's controls, then go to IDLE.
- `EX_Stall` = (IDLE and ALUOp==MUL) OR BUSY. It is combinational and deasserted in DONE.
- While `EX_Stall`=1 and `MemoryStall`=0, EX/MEM loads a bubble: all control bits 0, result 0, WriteReg 0.
- `MemoryStall`=1 freezes EX/MEM, the FSM, the counter and the accumulator; the registers keep their values.

## Timing
- ALU ops have 1-cycle latency: the ID/EX value at edge N appears on EX/MEM after edge N+1.
- MUL appears on EX/MEM after edge N+MUL_CYCLES+2 when no `MemoryStall` occurs. Each `MemoryStall` cycle extends this by one.
- Reset (`rst_n`=0, asynchronous) gives:
  - FSM in IDLE, counter 0.
  - All EX/MEM outputs 0.
  - `EX_Stall` depends only on ID/EX; upstream resets ID/EX ALUOp to NOP, so `EX_Stall`=0.
- Reset during BUSY abandons the multiply; no partial result is ever written.
- A MUL directly followed by a dependent instruction: that instruction is held in ID/EX through DONE, then forwards the product from EX/MEM on the next cycle.
- A simultaneous hit in EX/MEM and MEM/WB for the same register selects EX/MEM.

## Test plan
- After reset, with ALUOp NOP, all outputs are 0 and `EX_Stall`=0.
- ADD with A=5 and B=imm 0xFFFF_FFFD (sign-extended) -> `EX_MEM_ALUResult`=2 one cycle later.
- Back-to-back ADD writing r3, then SUB reading r3, with regfile value stale=0 -> SUB uses the forwarded EX/MEM value. With only MEM/WB writing r3=7, the SUB uses 7. Forwarding on r0 never occurs.
- MUL 0x0001_0003 × 0x0000_0100 -> `EX_Stall` high for 33 cycles, RegWrite bubbles meanwhile, then product 0x0100_0300 with RegWrite=1.
- `MemoryStall` pulsed 3 cycles mid-multiply -> completes 3 cycles later with the same product; EX/MEM unchanged while stalled.
- Branch=1 with A=B=0x10 -> BranchTaken=1 and target passed through; A≠B -> BranchTaken=0. `rst_n` low mid-MUL -> outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: EX/MEM and MEM/WB operand forwarding, single-cycle ALU,
// branch resolution and a shift-add multiplier that stalls upstream while busy.
module ex_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_MemToReg,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MemWrite,
  input  logic        ID_EX_Branch,
  input  logic        ID_EX_ALUSrc,
  input  logic [5:0]  ID_EX_ALUOp,
  input  logic [31:0] ID_EX_BranchTarget,
  input  logic [31:0] ID_EX_ReadData1,
  input  logic [31:0] ID_EX_ReadData2,
  input  logic [31:0] ID_EX_SignExtImm,
  input  logic [4:0]  ID_EX_Rs,
  input  logic [4:0]  ID_EX_WriteReg,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] MEM_WB_WriteData,
  input  logic        MemoryStall,
  output logic        EX_Stall,
  output logic        EX_MEM_MemToReg,
  output logic        EX_MEM_RegWrite,
  output logic        EX_MEM_MemRead,
  output logic        EX_MEM_MemWrite,
  output logic        EX_MEM_BranchTaken,
  output logic [31:0] EX_MEM_ALUResult,
  output logic [31:0] EX_MEM_StoreData,
  output logic [31:0] EX_MEM_BranchTarget,
  output logic [4:0]  EX_MEM_WriteReg
);

  localparam int            CW       = $clog2(MUL_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_SLL = 6'b000110;
  localparam logic [5:0] OP_SRL = 6'b000111;
  localparam logic [5:0] OP_MUL = 6'b001000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mcand;
  logic [31:0]   r_mplier;
  logic [31:0]   r_acc;

  logic        r_mul_memtoreg;
  logic        r_mul_regwrite;
  logic        r_mul_memread;
  logic        r_mul_memwrite;
  logic        r_mul_taken;
  logic [31:0] r_mul_store;
  logic [31:0] r_mul_target;
  logic [4:0]  r_mul_wreg;

  logic        r_exm_memtoreg;
  logic        r_exm_regwrite;
  logic        r_exm_memread;
  logic        r_exm_memwrite;
  logic        r_exm_taken;
  logic [31:0] r_exm_result;
  logic [31:0] r_exm_store;
  logic [31:0] r_exm_target;
  logic [4:0]  r_exm_wreg;

  logic [31:0] w_op_a;
  logic [31:0] w_store;
  logic [31:0] w_op_b;
  logic [31:0] w_alu;
  logic        w_is_mul;
  logic        w_taken;
  logic        w_ex_stall;

  // Operand forwarding; EX/MEM beats MEM/WB, register 0 is never forwarded
  always_comb begin
    w_op_a  = ID_EX_ReadData1;
    w_store = ID_EX_ReadData2;
    if ((ID_EX_Rs != 5'd0) && r_exm_regwrite && !r_exm_memtoreg && (r_exm_wreg == ID_EX_Rs)) begin
      w_op_a = r_exm_result;
    end else if ((ID_EX_Rs != 5'd0) && MEM_WB_RegWrite && (MEM_WB_WriteReg == ID_EX_Rs)) begin
      w_op_a = MEM_WB_WriteData;
    end else begin
      w_op_a = ID_EX_ReadData1;
    end
    if ((ID_EX_WriteReg != 5'd0) && r_exm_regwrite && !r_exm_memtoreg && (r_exm_wreg == ID_EX_WriteReg)) begin
      w_store = r_exm_result;
    end else if ((ID_EX_WriteReg != 5'd0) && MEM_WB_RegWrite && (MEM_WB_WriteReg == ID_EX_WriteReg)) begin
      w_store = MEM_WB_WriteData;
    end else begin
      w_store = ID_EX_ReadData2;
    end
  end

  assign w_op_b   = ID_EX_ALUSrc ? ID_EX_SignExtImm : w_store;
  assign w_is_mul = (ID_EX_ALUOp == OP_MUL);
  assign w_taken  = ID_EX_Branch && (w_op_a == w_store);

  // Single-cycle ALU; unknown codes and MUL produce 0 on this path
  always_comb begin
    w_alu = 32'd0;
    case (ID_EX_ALUOp)
      OP_ADD:  w_alu = w_op_a + w_op_b;
      OP_SUB:  w_alu = w_op_a - w_op_b;
      OP_AND:  w_alu = w_op_a & w_op_b;
      OP_OR:   w_alu = w_op_a | w_op_b;
      OP_XOR:  w_alu = w_op_a ^ w_op_b;
      OP_SLT:  w_alu = ($signed(w_op_a) < $signed(w_op_b)) ? 32'd1 : 32'd0;
      OP_SLL:  w_alu = w_op_a << w_op_b[4:0];
      OP_SRL:  w_alu = w_op_a >> w_op_b[4:0];
      default: w_alu = 32'd0;
    endcase
  end

  // Multiplier next-state and stall; MemoryStall freezes every transition
  always_comb begin
    w_state_nxt = r_state;
    w_ex_stall  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ex_stall = w_is_mul;
        if (w_is_mul && !MemoryStall) begin
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        w_ex_stall = 1'b1;
        if (!MemoryStall && (r_cnt == CNT_LAST)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_BUSY;
        end
      end
      S_DONE: begin
        if (!MemoryStall) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shift-add datapath plus the MUL's own controls, captured at issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_mcand        <= 32'd0;
      r_mplier       <= 32'd0;
      r_acc          <= 32'd0;
      r_mul_memtoreg <= 1'b0;
      r_mul_regwrite <= 1'b0;
      r_mul_memread  <= 1'b0;
      r_mul_memwrite <= 1'b0;
      r_mul_taken    <= 1'b0;
      r_mul_store    <= 32'd0;
      r_mul_target   <= 32'd0;
      r_mul_wreg     <= 5'd0;
    end else if (!MemoryStall) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mul) begin
            r_cnt          <= '0;
            r_mcand        <= w_op_a;
            r_mplier       <= w_op_b;
            r_acc          <= 32'd0;
            r_mul_memtoreg <= ID_EX_MemToReg;
            r_mul_regwrite <= ID_EX_RegWrite;
            r_mul_memread  <= ID_EX_MemRead;
            r_mul_memwrite <= ID_EX_MemWrite;
            r_mul_taken    <= w_taken;
            r_mul_store    <= w_store;
            r_mul_target   <= ID_EX_BranchTarget;
            r_mul_wreg     <= ID_EX_WriteReg;
          end
        end
        S_BUSY: begin
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : 32'd0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // EX/MEM pipeline register: product in DONE, bubble while stalling, else ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exm_memtoreg <= 1'b0;
      r_exm_regwrite <= 1'b0;
      r_exm_memread  <= 1'b0;
      r_exm_memwrite <= 1'b0;
      r_exm_taken    <= 1'b0;
      r_exm_result   <= 32'd0;
      r_exm_store    <= 32'd0;
      r_exm_target   <= 32'd0;
      r_exm_wreg     <= 5'd0;
    end else if (!MemoryStall) begin
      if (r_state == S_DONE) begin
        r_exm_memtoreg <= r_mul_memtoreg;
        r_exm_regwrite <= r_mul_regwrite;
        r_exm_memread  <= r_mul_memread;
        r_exm_memwrite <= r_mul_memwrite;
        r_exm_taken    <= r_mul_taken;
        r_exm_result   <= r_acc;
        r_exm_store    <= r_mul_store;
        r_exm_target   <= r_mul_target;
        r_exm_wreg     <= r_mul_wreg;
      end else if (w_ex_stall) begin
        r_exm_memtoreg <= 1'b0;
        r_exm_regwrite <= 1'b0;
        r_exm_memread  <= 1'b0;
        r_exm_memwrite <= 1'b0;
        r_exm_taken    <= 1'b0;
        r_exm_result   <= 32'd0;
        r_exm_store    <= 32'd0;
        r_exm_target   <= 32'd0;
        r_exm_wreg     <= 5'd0;
      end else begin
        r_exm_memtoreg <= ID_EX_MemToReg;
        r_exm_regwrite <= ID_EX_RegWrite;
        r_exm_memread  <= ID_EX_MemRead;
        r_exm_memwrite <= ID_EX_MemWrite;
        r_exm_taken    <= w_taken;
        r_exm_result   <= w_alu;
        r_exm_store    <= w_store;
        r_exm_target   <= ID_EX_BranchTarget;
        r_exm_wreg     <= ID_EX_WriteReg;
      end
    end
  end

  assign EX_Stall            = w_ex_stall;
  assign EX_MEM_MemToReg     = r_exm_memtoreg;
  assign EX_MEM_RegWrite     = r_exm_regwrite;
  assign EX_MEM_MemRead      = r_exm_memread;
  assign EX_MEM_MemWrite     = r_exm_memwrite;
  assign EX_MEM_BranchTaken  = r_exm_taken;
  assign EX_MEM_ALUResult    = r_exm_result;
  assign EX_MEM_StoreData    = r_exm_store;
  assign EX_MEM_BranchTarget = r_exm_target;
  assign EX_MEM_WriteReg     = r_exm_wreg;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a cycle-level reference model predicts every
// EX/MEM load and EX_Stall value; two monitors pop and compare independently.
`timescale 1ns/1ps
module tb_ex_stage;
  localparam int MUL_CYCLES = 32;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, MUL = 6'd8, NOP = 6'd21;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mtr, rw, mr, mw, br, alusrc, ms;
  logic [5:0]  op;
  logic [31:0] bta, rd1, rd2, imm;
  logic [4:0]  rs, wreg;
  logic        mwb_rw;
  logic [4:0]  mwb_wr;
  logic [31:0] mwb_wd;

  logic        EX_Stall, o_mtr, o_rw, o_mr, o_mw, o_bt;
  logic [31:0] o_res, o_sd, o_bta;
  logic [4:0]  o_wr;

  ex_stage #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemToReg(mtr), .ID_EX_RegWrite(rw), .ID_EX_MemRead(mr), .ID_EX_MemWrite(mw),
    .ID_EX_Branch(br), .ID_EX_ALUSrc(alusrc), .ID_EX_ALUOp(op),
    .ID_EX_BranchTarget(bta), .ID_EX_ReadData1(rd1), .ID_EX_ReadData2(rd2),
    .ID_EX_SignExtImm(imm), .ID_EX_Rs(rs), .ID_EX_WriteReg(wreg),
    .MEM_WB_RegWrite(mwb_rw), .MEM_WB_WriteReg(mwb_wr), .MEM_WB_WriteData(mwb_wd),
    .MemoryStall(ms), .EX_Stall(EX_Stall),
    .EX_MEM_MemToReg(o_mtr), .EX_MEM_RegWrite(o_rw), .EX_MEM_MemRead(o_mr),
    .EX_MEM_MemWrite(o_mw), .EX_MEM_BranchTaken(o_bt), .EX_MEM_ALUResult(o_res),
    .EX_MEM_StoreData(o_sd), .EX_MEM_BranchTarget(o_bta), .EX_MEM_WriteReg(o_wr)
  );

  typedef struct packed {
    logic mtr, rw, mr, mw, bt;
    logic [31:0] res, sd, bta;
    logic [4:0] wr;
  } exm_t;

  exm_t exp_q[$];
  logic stall_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: architectural EX/MEM contents and pending multiply
  exm_t m_exm, m_mul;
  int   m_rem;
  logic m_hold;
  logic last_dut_stall;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exm_t dut_exm();
    return {o_mtr, o_rw, o_mr, o_mw, o_bt, o_res, o_sd, o_bta, o_wr};
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] v);
    if (src != 5'd0 && m_exm.rw && !m_exm.mtr && m_exm.wr == src) return m_exm.res;
    if (src != 5'd0 && mwb_rw && mwb_wr == src) return mwb_wd;
    return v;
  endfunction

  // Predict stall now and EX/MEM after the coming edge from current inputs
  task automatic step();
    logic [31:0] a, sd, b, res;
    logic st;
    exm_t nx;
    a  = fwd(rs, rd1);
    sd = fwd(wreg, rd2);
    b  = alusrc ? imm : sd;
    case (op)
      6'd0: res = a + b;
      6'd1: res = a - b;
      6'd2: res = a & b;
      6'd3: res = a | b;
      6'd4: res = a ^ b;
      6'd5: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd6: res = a << b[4:0];
      6'd7: res = a >> b[4:0];
      6'd8: res = a * b;
      default: res = 32'd0;
    endcase
    if (m_rem == 0) st = (op == MUL);
    else st = (m_rem > 1);
    stall_q.push_back(st);
    nx = m_exm;
    if (!ms) begin
      if (m_rem == 1) begin
        nx = m_mul;
        m_rem = 0;
      end else if (st) begin
        nx = '0;
        if (m_rem == 0) begin
          m_rem = MUL_CYCLES + 1;
          m_mul = {mtr, rw, mr, mw, br && (a == sd), res, sd, bta, wreg};
        end else begin
          m_rem--;
        end
      end else begin
        nx = {mtr, rw, mr, mw, br && (a == sd), res, sd, bta, wreg};
      end
    end
    exp_q.push_back(nx);
    m_exm  = nx;
    m_hold = st || ms;
  endtask

  task automatic tick();
    #1;
    last_dut_stall = EX_Stall;
    step();
    @(negedge clk);
  endtask

  task automatic instr(input logic [5:0] o, input logic [4:0] s, input logic [31:0] v1,
                       input logic [4:0] w, input logic [31:0] v2, input logic src,
                       input logic [31:0] im, input logic wen, input logic b);
    op = o; rs = s; rd1 = v1; wreg = w; rd2 = v2; alusrc = src; imm = im;
    rw = wen; br = b; mtr = 1'b0; mr = 1'b0; mw = 1'b0; bta = 32'h0000_ABC0;
  endtask

  task automatic mwb(input logic e, input logic [4:0] w, input logic [31:0] d);
    mwb_rw = e; mwb_wr = w; mwb_wd = d;
  endtask

  task automatic rand_idex();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 8) op = 6'(r);
    else if (r < 12) op = NOP;
    else op = 6'($urandom_range(0, 63));
    mtr = 1'($urandom); rw = 1'($urandom); mr = 1'($urandom); mw = 1'($urandom);
    br = 1'($urandom); alusrc = 1'($urandom);
    rs = 5'($urandom_range(0, 3)); wreg = 5'($urandom_range(0, 3));
    rd1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    rd2 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
    bta = $urandom;
  endtask

  function automatic void model_reset();
    m_exm = '0; m_mul = '0; m_rem = 0; m_hold = 1'b0;
  endfunction

  // Monitor: EX/MEM after each rising edge
  initial begin
    exm_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("exmem", dut_exm(), e);
      end
    end
  end

  // Monitor: combinational EX_Stall once inputs have settled
  initial begin
    logic s;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) begin
        s = stall_q.pop_front();
        check("ex_stall", EX_Stall, s);
      end
    end
  end

  initial begin
    int n, nst;
    rst_n = 1'b0; ms = 1'b0;
    instr(NOP, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    mwb(1'b0, 5'd0, 32'd0);
    model_reset();
    @(negedge clk); #1;
    check("reset_exmem", dut_exm(), 106'd0);
    check("reset_stall", EX_Stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    instr(ADD, 5'd1, 32'd5, 5'd3, 32'd0, 1'b1, 32'hFFFF_FFFD, 1'b1, 1'b0); tick();
    check("add_imm", o_res, 32'd2);
    instr(SUB, 5'd3, 32'd0, 5'd4, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0); tick();
    check("fwd_exmem", o_res, 32'd1);
    instr(NOP, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0); tick();
    mwb(1'b1, 5'd3, 32'd7);
    instr(SUB, 5'd3, 32'd0, 5'd9, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0); tick();
    check("fwd_memwb", o_res, 32'd7);
    mwb(1'b1, 5'd0, 32'd99);
    instr(ADD, 5'd0, 32'h11, 5'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0); tick();
    check("r0_memwb", o_res, 32'h11);
    mwb(1'b0, 5'd0, 32'd0);
    instr(ADD, 5'd0, 32'h22, 5'd5, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0); tick();
    check("r0_exmem", o_res, 32'h22);
    mwb(1'b1, 5'd5, 32'h777);
    instr(ADD, 5'd5, 32'd0, 5'd6, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0); tick();
    check("both_hit", o_res, 32'h22);
    mwb(1'b0, 5'd0, 32'd0);
    instr(NOP, 5'd10, 32'h10, 5'd11, 32'h10, 1'b0, 32'd0, 1'b0, 1'b1); tick();
    check("br_taken", o_bt, 1'b1);
    check("br_target", o_bta, 32'h0000_ABC0);
    instr(NOP, 5'd10, 32'h10, 5'd11, 32'h11, 1'b0, 32'd0, 1'b0, 1'b1); tick();
    check("br_not_taken", o_bt, 1'b0);

    instr(MUL, 5'd1, 32'h0001_0003, 5'd8, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);
    n = 0; nst = 0;
    do begin
      tick();
      n++;
      if (last_dut_stall) nst++;
    end while (m_rem != 0 && n < 80);
    check("mul_stall_cycles", nst, 33);
    check("mul_latency", n, 34);
    check("mul_product", o_res, 32'h0100_0300);
    check("mul_regwrite", o_rw, 1'b1);

    instr(MUL, 5'd1, 32'h0001_0003, 5'd12, 32'd0, 1'b1, 32'h100, 1'b1, 1'b0);
    tick(); n = 1;
    repeat (10) begin tick(); n++; end
    ms = 1'b1;
    repeat (3) begin tick(); n++; end
    ms = 1'b0;
    while (!o_rw && n < 80) begin tick(); n++; end
    check("mul_ms_latency", n, 37);
    check("mul_ms_product", o_res, 32'h0100_0300);
    instr(ADD, 5'd12, 32'd0, 5'd13, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0); tick();
    check("mul_dep_fwd", o_res, 32'h0100_0301);

    instr(MUL, 5'd1, 32'h1234_5678, 5'd14, 32'd0, 1'b1, 32'h9, 1'b1, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    instr(NOP, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    #1;
    check("rst_mid_mul_exmem", dut_exm(), 106'd0);
    check("rst_mid_mul_stall", EX_Stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    for (int i = 0; i < 700; i++) begin
      if (!m_hold) rand_idex();
      mwb(1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      ms = ($urandom_range(0, 7) == 0);
      tick();
    end
    ms = 1'b0;
    instr(NOP, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (m_rem != 0 && n < 100) begin tick(); n++; end
    tick();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
